// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit for the EX stage.
// Holds the HI/LO registers and raises busy for a fixed latency, so the
// hazard unit can stall HI/LO users and any new mult/div.
module mdu_ctrl #(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  mdu_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        wr_hi,
   input  logic        wr_lo,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   // The counter only ever holds LAT-1, so clog2(MAX_LAT) bits are enough.
   localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] DIV_INIT = CW'(DIV_LAT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_DIVU  = 2'd3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [1:0]    op_r, op_s;
   logic [31:0]   a_r, a_s;
   logic [31:0]   b_r, b_s;
   logic          busy_r, busy_s;
   logic [31:0]   hi_r, hi_s;
   logic [31:0]   lo_r, lo_s;

   logic [63:0]   mul_a_s, mul_b_s, prod_s;
   logic          a_neg_s, b_neg_s;
   logic [31:0]   a_mag_s, b_mag_s;
   logic [31:0]   uquo_s, urem_s;
   logic [31:0]   quo_s, rem_s;

   // Result datapath: works only on the latched operands, never on live a/b.
   always_comb begin
      mul_a_s = (op_r == OP_MULT) ? {{32{a_r[31]}}, a_r} : {32'd0, a_r};
      mul_b_s = (op_r == OP_MULT) ? {{32{b_r[31]}}, b_r} : {32'd0, b_r};
      prod_s  = mul_a_s * mul_b_s;

      // Signed divide = unsigned divide of magnitudes, then sign fix-up:
      // quotient truncates toward zero, remainder follows the dividend.
      a_neg_s = (op_r == OP_DIV) && a_r[31];
      b_neg_s = (op_r == OP_DIV) && b_r[31];
      a_mag_s = a_neg_s ? (32'd0 - a_r) : a_r;
      b_mag_s = b_neg_s ? (32'd0 - b_r) : b_r;
      if (b_mag_s != 32'd0) begin
         uquo_s = a_mag_s / b_mag_s;
         urem_s = a_mag_s % b_mag_s;
      end else begin
         uquo_s = 32'd0;
         urem_s = 32'd0;
      end
      quo_s = (a_neg_s ^ b_neg_s) ? (32'd0 - uquo_s) : uquo_s;
      rem_s = a_neg_s ? (32'd0 - urem_s) : urem_s;
   end

   // Sequencer next-state, operand capture and HI/LO update.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      op_s    = op_r;
      a_s     = a_r;
      b_s     = b_r;
      busy_s  = busy_r;
      hi_s    = hi_r;
      lo_s    = lo_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               // start beats mthi/mtlo issued in the same cycle
               state_s = RUN;
               op_s    = mdu_op;
               a_s     = a;
               b_s     = b;
               cnt_s   = mdu_op[1] ? DIV_INIT : MUL_INIT;
               busy_s  = 1'b1;
            end else begin
               if (wr_hi) begin
                  hi_s = a;
               end else begin
                  hi_s = hi_r;
               end
               if (wr_lo) begin
                  lo_s = a;
               end else begin
                  lo_s = lo_r;
               end
            end
         end
         RUN: begin
            // start, wr_hi and wr_lo are deliberately ignored while running
            if (cnt_r != CNT_ZERO) begin
               cnt_s = cnt_r - CNT_ONE;
            end else begin
               state_s = IDLE;
               busy_s  = 1'b0;
               case (op_r)
                  OP_MULT, OP_MULTU: begin
                     hi_s = prod_s[63:32];
                     lo_s = prod_s[31:0];
                  end
                  OP_DIV, OP_DIVU: begin
                     // divide by zero leaves HI/LO untouched
                     if (b_r != 32'd0) begin
                        hi_s = rem_s;
                        lo_s = quo_s;
                     end else begin
                        hi_s = hi_r;
                        lo_s = lo_r;
                     end
                  end
                  default: begin
                     hi_s = hi_r;
                     lo_s = lo_r;
                  end
               endcase
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers; synchronous reset aborts any op in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         op_r    <= 2'd0;
         a_r     <= 32'd0;
         b_r     <= 32'd0;
         busy_r  <= 1'b0;
         hi_r    <= 32'd0;
         lo_r    <= 32'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         op_r    <= op_s;
         a_r     <= a_s;
         b_r     <= b_s;
         busy_r  <= busy_s;
         hi_r    <= hi_s;
         lo_r    <= lo_s;
      end
   end

   assign busy = busy_r;
   assign hi   = hi_r;
   assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed, table-driven bench for mdu_ctrl plus hand-written
// sequences for interference, same-cycle priority, back-to-back and reset abort.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  mdu_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        wr_hi;
   logic        wr_lo;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .mdu_op (mdu_op),
      .a      (a),
      .b      (b),
      .wr_hi  (wr_hi),
      .wr_lo  (wr_lo),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          lat;
   } vec_t;

   vec_t vecs[10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic preset(input logic [31:0] ph, input logic [31:0] pl);
      wr_hi = 1'b1; a = ph; step(); wr_hi = 1'b0;
      wr_lo = 1'b1; a = pl; step(); wr_lo = 1'b0;
   endtask

   // Launch an op, drop start after the launch edge, count busy cycles (bounded).
   task automatic run_op(input logic [1:0] op, input logic [31:0] oa, input logic [31:0] ob,
                         output int cycles);
      mdu_op = op; a = oa; b = ob; start = 1'b1;
      step();
      start = 1'b0;
      cycles = 0;
      while (busy && cycles < 50) begin
         cycles++;
         step();
      end
   endtask

   initial begin
      int cyc;
      int n;

      vecs[0] = '{"mult_neg1x2",  2'd0, 32'hFFFFFFFF, 32'd2,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
      vecs[1] = '{"multu_ffx2",   2'd1, 32'hFFFFFFFF, 32'd2,        32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFE, 5};
      vecs[2] = '{"mult_pos",     2'd0, 32'h12345678, 32'h10,       32'h0, 32'h0, 32'h00000001, 32'h23456780, 5};
      vecs[3] = '{"multu_max",    2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 5};
      vecs[4] = '{"div_m7_2",     2'd2, 32'hFFFFFFF9, 32'd2,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[5] = '{"div_7_m2",     2'd2, 32'd7,        32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, 10};
      vecs[6] = '{"divu_7_2",     2'd3, 32'd7,        32'd2,        32'h0, 32'h0, 32'h00000001, 32'h00000003, 10};
      vecs[7] = '{"divu_by0",     2'd3, 32'd7,        32'd0,        32'hAA, 32'hBB, 32'h000000AA, 32'h000000BB, 10};
      vecs[8] = '{"div_min_m1",   2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h55, 32'h66, 32'h00000000, 32'h80000000, 10};
      vecs[9] = '{"div_by0",      2'd2, 32'hFFFFFFF0, 32'd0,        32'h11, 32'h22, 32'h00000011, 32'h00000022, 10};

      reset = 1'b1; start = 1'b0; mdu_op = 2'd0; a = 32'd0; b = 32'd0;
      wr_hi = 1'b0; wr_lo = 1'b0;
      step(); step();
      reset = 1'b0;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);

      // mthi / mtlo in idle
      wr_hi = 1'b1; a = 32'h1234; step(); wr_hi = 1'b0;
      chk("mthi_hi", hi, 32'h00001234);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      chk("mthi_lo_kept", lo, 32'd0);
      wr_hi = 1'b1; wr_lo = 1'b1; a = 32'hCAFE0001; step(); wr_hi = 1'b0; wr_lo = 1'b0;
      chk("mthilo_hi", hi, 32'hCAFE0001);
      chk("mthilo_lo", lo, 32'hCAFE0001);

      // Table-driven operations
      for (int i = 0; i < 10; i++) begin
         preset(vecs[i].pre_hi, vecs[i].pre_lo);
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
         chk({vecs[i].name, "_lat"}, 32'(cyc), 32'(vecs[i].lat));
         chk({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
         chk({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
         step();
      end

      // Interference during a mult: start(div), mtlo and operand changes ignored
      preset(32'h9, 32'h8);
      mdu_op = 2'd0; a = 32'd3; b = 32'd5; start = 1'b1;
      step();
      mdu_op = 2'd2; a = 32'd5; b = 32'd0; start = 1'b1; wr_lo = 1'b1;
      step();
      start = 1'b0; wr_lo = 1'b0; a = 32'hDEAD; b = 32'hBEEF;
      chk("intf_lo_hold", lo, 32'h8);
      chk("intf_busy", {31'd0, busy}, 32'd1);
      cyc = 2;
      while (busy && cyc < 50) begin
         cyc++;
         step();
      end
      chk("intf_lat", 32'(cyc - 1), 32'd5);
      chk("intf_hi", hi, 32'd0);
      chk("intf_lo", lo, 32'd15);
      step();
      chk("intf_no_div", {31'd0, busy}, 32'd0);

      // start together with mthi in idle: only the op happens
      preset(32'h77, 32'h66);
      mdu_op = 2'd1; a = 32'd2; b = 32'd3; start = 1'b1; wr_hi = 1'b1;
      step();
      start = 1'b0; wr_hi = 1'b0;
      chk("sw_busy", {31'd0, busy}, 32'd1);
      chk("sw_hi_hold", hi, 32'h77);
      n = 0;
      while (busy && n < 50) begin
         n++;
         step();
      end
      chk("sw_hi", hi, 32'd0);
      chk("sw_lo", lo, 32'd6);

      // Back-to-back with start held: exactly one idle cycle between ops
      mdu_op = 2'd1; a = 32'd4; b = 32'd4; start = 1'b1;
      step();
      n = 0;
      while (busy && n < 50) begin
         n++;
         step();
      end
      chk("b2b_lat", 32'(n), 32'd5);
      chk("b2b_lo", lo, 32'd16);
      step();
      start = 1'b0;
      chk("b2b_restart", {31'd0, busy}, 32'd1);
      n = 0;
      while (busy && n < 50) begin
         n++;
         step();
      end
      chk("b2b_lat2", 32'(n), 32'd5);

      // Reset in the 3rd busy cycle of a div aborts it
      preset(32'h12, 32'h34);
      mdu_op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      for (int k = 0; k < 12; k++) step();
      chk("rst_late_busy", {31'd0, busy}, 32'd0);
      chk("rst_late_hi", hi, 32'd0);
      chk("rst_late_lo", lo, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
